// File: rtl/clk_div_bank.sv
// clk_div_bank: programmable 50%-duty clock dividers with glitch-free retune, stop and phase resync
module clk_div_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 1
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    logic [NUM_CH-1:0] pend_vec;
    logic [15:0]       pend_x;
    logic              cfg_oor, cfg_err_d, cfg_err_q;
    always_comb begin
        pend_x    = 16'(pend_vec);
        cfg_oor   = int'(cfg_ch) >= NUM_CH;
        cfg_ready = cfg_oor || !pend_x[cfg_ch];
        cfg_err_d = cfg_valid && cfg_oor;
    end
    always_ff @(posedge clk_50 or negedge rst_n)
        if (!rst_n) cfg_err_q <= 1'b0;
        else        cfg_err_q <= cfg_err_d;
    assign cfg_err = cfg_err_q;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
        logic             pend_q, pend_d, clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
        logic             run, tgl, wr, stop_now, apply;
        always_comb begin
            run      = st_q != IDLE;
            tgl      = run && cnt_q == act_q;
            wr       = cfg_valid && cfg_ch == 4'(i) && !pend_q;
            // enable dropped while low: stop at once rather than start a new high phase
            stop_now = run && !ch_en[i] && !clk_q;
            apply    = pend_q && (!run || tgl || sync);
            cnt_d    = (!run || sync || stop_now || tgl) ? '0 : cnt_q + 1'b1;
            clk_d    = run && !sync && !stop_now && (clk_q ^ tgl);
            st_d     = !run     ? (ch_en[i] ? RUN : IDLE)
                     : sync     ? (st_q == STOPPING ? IDLE : RUN)
                     : stop_now ? IDLE
                     : ch_en[i] ? RUN
                     : tgl      ? IDLE : STOPPING;
            act_d    = apply ? shd_q : act_q;
            shd_d    = wr ? cfg_div : shd_q;
            pend_d   = apply ? 1'b0 : (wr || pend_q);
            rise_d   = clk_d && !clk_q;
            fall_d   = !clk_d && clk_q;
        end
        always_ff @(posedge clk_50 or negedge rst_n)
            if (!rst_n) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                act_q  <= CNT_W'(DIV_RST);
                shd_q  <= CNT_W'(DIV_RST);
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        assign pend_vec[i] = pend_q;
        assign clk_out[i]  = clk_q;
        assign rise[i]     = rise_q;
        assign fall[i]     = fall_q;
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed stimulus with a behavioural half-period model plus literal pins
module tb_clk_div_bank;
    localparam int N = 4;
    logic       clk_50, rst_n, sync, cfg_valid, cfg_ready, cfg_err;
    logic [3:0] ch_en, cfg_ch, clk_out, rise, fall;
    logic [7:0] cfg_div;

    clk_div_bank dut (
        .clk_50(clk_50), .rst_n(rst_n), .ch_en(ch_en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .clk_out(clk_out), .rise(rise), .fall(fall)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // model: each running channel holds a level and the edges left until it flips
    logic [3:0] m_hi, m_rise, m_fall, m_pend, m_idle, m_stop;
    logic       m_err;
    int         m_left[N], m_div[N], m_shd[N];

    logic [3:0] lo_clk, lo_rise, lo_fall;
    logic       lo_on, lc_on, lc_rdy, lc_err, wr_chk, wr_acc;
    int         n_vec = 0, n_bad = 0;

    task automatic model_reset();
        m_hi = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_idle = '1; m_stop = 0; m_err = 0;
        for (int c = 0; c < N; c++) begin m_div[c] = 1; m_shd[c] = 1; m_left[c] = 0; end
    endtask

    task automatic model_step();
        bit acc, was;
        if (!rst_n) begin model_reset(); return; end
        m_err = cfg_valid && int'(cfg_ch) >= N;
        for (int c = 0; c < N; c++) begin
            acc = cfg_valid && int'(cfg_ch) == c && !m_pend[c];
            was = m_hi[c];
            if (m_idle[c]) begin
                if (m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 0; end
                if (ch_en[c]) begin m_idle[c] = 0; m_stop[c] = 0; m_left[c] = m_div[c] + 1; end
            end else if (sync) begin
                if (m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 0; end
                m_hi[c] = 0; m_left[c] = m_div[c] + 1; m_idle[c] = m_stop[c]; m_stop[c] = 0;
            end else if (!ch_en[c] && !m_hi[c]) begin
                m_idle[c] = 1;
            end else begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_hi[c] = !m_hi[c];
                    if (m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 0; end
                    m_left[c] = m_div[c] + 1;
                end
                m_stop[c] = !ch_en[c] && m_hi[c];
                if (!ch_en[c] && !m_hi[c]) m_idle[c] = 1;
            end
            if (acc) begin m_shd[c] = int'(cfg_div); m_pend[c] = 1; end
            m_rise[c] = m_hi[c] && !was;
            m_fall[c] = !m_hi[c] && was;
        end
    endtask

    function automatic logic exp_rdy();
        return int'(cfg_ch) >= N ? 1'b1 : !m_pend[cfg_ch[1:0]];
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_50) begin
        chk("clk_out", clk_out, m_hi);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("cfg_err", {3'b0, cfg_err}, {3'b0, m_err});
        chk("cfg_ready", {3'b0, cfg_ready}, {3'b0, exp_rdy()});
        if (lo_on) begin
            chk("lit_clk_out", clk_out, lo_clk);
            chk("lit_rise", rise, lo_rise);
            chk("lit_fall", fall, lo_fall);
        end
        if (lc_on) begin
            chk("lit_cfg_ready", {3'b0, cfg_ready}, {3'b0, lc_rdy});
            chk("lit_cfg_err", {3'b0, cfg_err}, {3'b0, lc_err});
        end
        if (wr_chk) chk("cfg_accept", {3'b0, wr_acc}, 4'b0001);
    end

    task automatic tick();
        @(posedge clk_50);
        model_step();
        #1;
        lo_on = 0; lc_on = 0; wr_chk = 0;
    endtask

    task automatic lo(input logic [3:0] c, input logic [3:0] r, input logic [3:0] f);
        lo_on = 1; lo_clk = c; lo_rise = r; lo_fall = f;
    endtask

    task automatic lc(input logic rdy, input logic err);
        lc_on = 1; lc_rdy = rdy; lc_err = err;
    endtask

    task automatic ticks(input int n, input logic [3:0] c, input logic [3:0] r, input logic [3:0] f);
        repeat (n) begin tick(); lo(c, r, f); end
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [7:0] d);
        int k = 0;
        cfg_valid = 1; cfg_ch = ch; cfg_div = d;
        #1;
        while (!cfg_ready && k < 50) begin tick(); k++; end
        tick();
        cfg_valid = 0;
        wr_chk = 1; wr_acc = k < 50;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        lo_on = 0; lc_on = 0; wr_chk = 0; wr_acc = 0;
        lo_clk = 0; lo_rise = 0; lo_fall = 0; lc_rdy = 0; lc_err = 0;
        rst_n = 0; ch_en = 0; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
        model_reset();
        repeat (3) begin tick(); lo(0, 0, 0); lc(1, 0); end
        // defaults: period 4, first rise two edges after enable is sampled
        rst_n = 1; ch_en = 4'b0001;
        ticks(2, 0, 0, 0);
        ticks(1, 1, 1, 0);
        ticks(1, 1, 0, 0);
        ticks(1, 0, 0, 1);
        ticks(1, 0, 0, 0);
        ticks(1, 1, 1, 0);
        // retune to 4 mid-high: high finishes at 2, next low lasts 5
        cfg_valid = 1; cfg_ch = 0; cfg_div = 4; lc(1, 0);
        tick(); cfg_valid = 0; lo(1, 0, 0); lc(0, 0);
        tick(); lo(0, 0, 1); lc(1, 0);
        ticks(4, 0, 0, 0);
        ticks(1, 1, 1, 0);
        ticks(1, 1, 0, 0);
        // stop one cycle after rise: full 5-cycle high, then idle
        ch_en = 0;
        ticks(3, 1, 0, 0);
        ticks(1, 0, 0, 1);
        ticks(3, 0, 0, 0);
        ch_en = 1;
        ticks(5, 0, 0, 0);
        ticks(1, 1, 1, 0);
        // brief drop during STOPPING leaves the period untouched
        ch_en = 0;
        ticks(1, 1, 0, 0);
        ch_en = 1;
        ticks(3, 1, 0, 0);
        ticks(1, 0, 0, 1);
        ticks(4, 0, 0, 0);
        ticks(1, 1, 1, 0);
        // three channels, divisors 1/2/3, then sync
        ch_en = 0;
        repeat (12) tick();
        cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, 3);
        tick();
        ch_en = 4'b0111;
        ticks(2, 0, 0, 0);
        ticks(1, 4'b0001, 4'b0001, 4'b0000);
        ticks(1, 4'b0011, 4'b0010, 4'b0000);
        ticks(1, 4'b0110, 4'b0100, 4'b0001);
        sync = 1;
        tick(); sync = 0; lo(0, 0, 4'b0110);
        ticks(1, 0, 0, 0);
        ticks(1, 4'b0001, 4'b0001, 4'b0000);
        ticks(1, 4'b0011, 4'b0010, 4'b0000);
        ticks(1, 4'b0110, 4'b0100, 4'b0001);
        repeat (10) tick();
        // out-of-range write, then divisor 0 on channel 3
        ch_en = 0;
        repeat (12) tick();
        cfg_valid = 1; cfg_ch = 7; cfg_div = 9; lc(1, 0);
        tick(); cfg_valid = 0; lc(1, 1);
        tick(); lc(1, 0);
        cfg_write(3, 0);
        tick();
        ch_en = 4'b1000;
        ticks(1, 0, 0, 0);
        ticks(1, 4'b1000, 4'b1000, 4'b0000);
        ticks(1, 4'b0000, 4'b0000, 4'b1000);
        ticks(1, 4'b1000, 4'b1000, 4'b0000);
        ticks(1, 4'b0000, 4'b0000, 4'b1000);
        // async reset with a write still pending on channel 0
        ch_en = 4'b1001;
        repeat (7) tick();
        cfg_valid = 1; cfg_ch = 0; cfg_div = 5;
        tick();
        cfg_valid = 0; rst_n = 0; model_reset(); lo(0, 0, 0); lc(1, 0);
        tick(); lo(0, 0, 0); lc(1, 0);
        rst_n = 1; ch_en = 4'b0001;
        ticks(2, 0, 0, 0);
        ticks(1, 1, 1, 0);
        ticks(1, 1, 0, 0);
        ticks(1, 0, 0, 1);
        ticks(1, 0, 0, 0);
        ticks(1, 1, 1, 0);
        // mixed traffic checked by the model alone
        cfg_write(1, 0);
        ch_en = 4'b1111;
        repeat (15) tick();
        sync = 1; tick(); sync = 0;
        ch_en = 4'b0101;
        repeat (6) tick();
        ch_en = 4'b1111;
        cfg_write(2, 5);
        cfg_write(2, 6);
        repeat (30) tick();
        @(negedge clk_50);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised multi-channel clock divider for the DDS waveform generator. Successor to the fixed single-channel 50→12.5 MHz divider.
- Produces NUM_CH independently programmable 50%-duty divided clocks from clk_50, each with one-cycle rise/fall strobes for use as clock enables.
- Adds glitch-free divisor updates at half-period boundaries, glitch-free enable/disable, and a global phase-resync.
- Feeds the codec master/bit clocks and the DDS sample-rate enables.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 8, width of half-period counter and divisor.
- DIV_RST, 1, reset value of every channel's active and shadow divisor (half period = DIV_RST+1 cycles; default gives 12.5 MHz).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- ch_en  in  NUM_CH  per-channel run enable, level.
- sync  in  1  one-cycle pulse; realigns all running channels.
- cfg_valid  in  1  divisor write request.
- cfg_ch  in  4  target channel index.
- cfg_div  in  CNT_W  new divisor; half period = cfg_div+1 cycles.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_err  out  1  one-cycle pulse when a write targets cfg_ch >= NUM_CH.
- clk_out  out  NUM_CH  divided clocks, registered.
- rise  out  NUM_CH  high for one cycle, coincident with the cycle clk_out[i] is first high.
- fall  out  NUM_CH  high for one cycle, coincident with the cycle clk_out[i] is first low.

Behaviour:
- Reset: all clk_out/rise/fall/cfg_err = 0; counters = 0; active = shadow = DIV_RST; pending = 0; all channels IDLE.
- Counter (RUN/STOPPING): if cnt == active, then cnt <= 0 and clk_out toggles; else cnt <= cnt+1. Half period = active+1 cycles. active = 0 gives clk_50/2.
- Per-channel FSM, IDLE / RUN / STOPPING:
  - IDLE: cnt = 0, clk_out = 0. ch_en = 1 → RUN. First rising edge of clk_out occurs active+1 cycles after ch_en is sampled.
  - RUN: ch_en = 0 with clk_out = 0 → IDLE next cycle, cnt cleared. ch_en = 0 with clk_out = 1 → STOPPING.
  - STOPPING: keeps counting. On the toggle to low → IDLE; fall strobes normally. If ch_en returns to 1 → RUN with no disturbance to cnt/clk_out.
  - Guarantee: no high pulse is ever shorter than active+1 cycles, except when truncated by sync.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] for in-range cfg_ch; cfg_ready = 1 for out-of-range cfg_ch.
  - An accepted in-range write sets shadow[ch] <= cfg_div and pending[ch] <= 1.
  - An out-of-range write is dropped and pulses cfg_err the next cycle.
  - cfg_valid must hold until accepted; no other requirement on the master.
- Divisor apply:
  - RUN/STOPPING: on a toggle cycle with pending set, active <= shadow, pending <= 0. The new value governs the next half period. A half period is never split between two divisors.
  - IDLE: apply on the cycle after acceptance.
  - A write accepted in the same cycle as a toggle waits for the next toggle.
- Sync:
  - All channels not IDLE: cnt <= 0, clk_out <= 0. Pending divisors are applied.
  - fall pulses if clk_out was 1. A STOPPING channel goes to IDLE.
  - Sync has priority over the toggle and ch_en in the same cycle; the high phase may be truncated.
  - IDLE channels are unaffected.
- rise/fall are registered on the same edge as clk_out; never both high.
- Asynchronous reset mid-operation: all state returns to reset values immediately; pending writes are lost.

Test Plan:
- Reset release, ch_en = 4'b0001, defaults → clk_out[0] period 4 cycles (2 high / 2 low), first rise 2 cycles after enable; rise/fall single-cycle and aligned; channels 1–3 stay 0.
- Running channel 0, write cfg_div = 4 mid-high-phase → current high phase completes at 2 cycles, following low phase is 5 cycles; cfg_ready low for ch 0 until the apply cycle.
- Deassert ch_en[0] one cycle after a rise, divisor 4 → high phase completes (5 cycles total), then clk_out = 0 and the channel is IDLE; reassert during STOPPING → uninterrupted 10-cycle period.
- Channels 0–2 running with divisors 1, 2, 3; pulse sync → all clk_out = 0 and cnt = 0 next cycle; subsequent rises at +2, +3, +4 cycles; fall pulses only for channels that were high.
- cfg_ch = 7 (NUM_CH = 4) → cfg_ready = 1, cfg_err one-cycle pulse, no divisor changes; divisor 0 → clk_out toggles every cycle (25 MHz).
- Assert rst_n low mid-period with a pending write → all outputs 0 immediately; after release, divisor = DIV_RST.
